// File: rtl/button_conditioner.sv
// button_conditioner: N-channel pushbutton front end.
// Each channel synchronises a raw button level, debounces it with a counter,
// emits press/release pulses and, when enabled, hold-to-auto-repeat pulses.
// All outputs are registered.
//
// Ports (top):
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   btn_in       raw button levels, 1 = pressed
//   level        debounced stable level
//   press_pulse  1-cycle pulse on accepted 0->1
//   rel_pulse    1-cycle pulse on accepted 1->0
//   rpt_pulse    1-cycle auto-repeat pulse while held
//   step_pulse   press_pulse | rpt_pulse
//   long_held    high while the channel is auto-repeating

// One conditioning lane: sync -> debounce -> press/hold/repeat FSM.
module button_channel #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 10,
    parameter int REPEAT_CYCLES   = 3,
    parameter bit REPEAT_ON       = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press_pulse,
    output logic rel_pulse,
    output logic rpt_pulse,
    output logic step_pulse,
    output logic long_held
);
    // Widths fall back to 1 bit when the terminal count is 0.
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HW = (HOLD_CYCLES > 1)     ? $clog2(HOLD_CYCLES)     : 1;
    localparam int RW = (REPEAT_CYCLES > 1)   ? $clog2(REPEAT_CYCLES)   : 1;
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] RPT_MAX  = RW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT_HOLD, REPEAT} state_t;

    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_out;
    logic                   stable;
    logic [DW-1:0]          cnt;
    logic [HW-1:0]          hcnt;
    logic [RW-1:0]          rcnt;
    state_t                 state;

    assign sync_out = sync[SYNC_STAGES-1];
    assign level    = stable;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], btn};
        end
    end

    // A new level is accepted only after DEBOUNCE_CYCLES consecutive mismatches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (sync_out == stable) begin
            cnt <= '0;
        end else if (cnt == DEB_MAX) begin
            stable <= sync_out;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Release takes priority in every state, so a repeat due on the same
    // edge as the release is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            hcnt        <= '0;
            rcnt        <= '0;
            press_pulse <= 1'b0;
            rel_pulse   <= 1'b0;
            rpt_pulse   <= 1'b0;
            step_pulse  <= 1'b0;
            long_held   <= 1'b0;
        end else begin
            press_pulse <= 1'b0;
            rel_pulse   <= 1'b0;
            rpt_pulse   <= 1'b0;
            step_pulse  <= 1'b0;
            case (state)
                IDLE: begin
                    if (stable) begin
                        press_pulse <= 1'b1;
                        step_pulse  <= 1'b1;
                        hcnt        <= '0;
                        state       <= WAIT_HOLD;
                    end
                end
                WAIT_HOLD: begin
                    if (!stable) begin
                        rel_pulse <= 1'b1;
                        state     <= IDLE;
                    end else if (hcnt == HOLD_MAX) begin
                        // Without repeat the lane parks here until release.
                        if (REPEAT_ON) begin
                            rpt_pulse  <= 1'b1;
                            step_pulse <= 1'b1;
                            rcnt       <= '0;
                            long_held  <= 1'b1;
                            state      <= REPEAT;
                        end
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!stable) begin
                        rel_pulse <= 1'b1;
                        long_held <= 1'b0;
                        state     <= IDLE;
                    end else if (rcnt == RPT_MAX) begin
                        rpt_pulse  <= 1'b1;
                        step_pulse <= 1'b1;
                        rcnt       <= '0;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                default: begin
                    long_held <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

module button_conditioner #(
    parameter int               N_BTN           = 5,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 4,
    parameter int               HOLD_CYCLES     = 10,
    parameter int               REPEAT_CYCLES   = 3,
    parameter logic [N_BTN-1:0] REPEAT_EN       = {N_BTN{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] rel_pulse,
    output logic [N_BTN-1:0] rpt_pulse,
    output logic [N_BTN-1:0] step_pulse,
    output logic [N_BTN-1:0] long_held
);
    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        button_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES),
            .REPEAT_ON      (REPEAT_EN[i])
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .btn        (btn_in[i]),
            .level      (level[i]),
            .press_pulse(press_pulse[i]),
            .rel_pulse  (rel_pulse[i]),
            .rpt_pulse  (rpt_pulse[i]),
            .step_pulse (step_pulse[i]),
            .long_held  (long_held[i])
        );
    end
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with N_BTN=2, REPEAT_EN=2'b01.
// Cycle index t counts rising edges from the first edge that samples the
// new button level; outputs are sampled 1 time unit after each edge.
// Observed/expected vectors pack {press, rel, rpt, step, long_held, level}.
module tb_button_conditioner;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] btn_in = 2'b00;
    logic [1:0] level, press_pulse, rel_pulse, rpt_pulse, step_pulse, long_held;

    int vectors = 0;
    int miscompares = 0;

    button_conditioner #(
        .N_BTN(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES(10), .REPEAT_CYCLES(3), .REPEAT_EN(2'b01)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .level(level),
        .press_pulse(press_pulse), .rel_pulse(rel_pulse), .rpt_pulse(rpt_pulse),
        .step_pulse(step_pulse), .long_held(long_held)
    );

    always #5 clk = ~clk;

    logic [11:0] got;
    assign got = {press_pulse, rel_pulse, rpt_pulse, step_pulse, long_held, level};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        btn_in = 2'b00;
        repeat (3) tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [11:0] exp;
        exp = '0;
        rst = 1'b0;
        btn_in = 2'b11;
        for (int t = 0; t < 3; t++) begin
            tick();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL reset_hold t=%0d got=%h exp=%h", t, got, exp);
            end
        end
        btn_in = 2'b00;
        rst = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL reset_idle t=%0d got=%h exp=%h", t, got, exp);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [11:0] exp;
        apply_reset();
        for (int t = 0; t <= 20; t++) begin
            btn_in = (t < 8) ? 2'b01 : 2'b00;
            tick();
            exp = {1'b0, t == 6, 1'b0, t == 14, 2'b00, 1'b0, t == 6, 2'b00,
                   1'b0, (t >= 5 && t <= 12)};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL clean_press t=%0d got=%h exp=%h", t, got, exp);
            end
        end
    endtask

    task automatic test_bounce();
        logic [11:0] exp;
        logic [3:0]  pat;
        pat = 4'b0101;  // bits applied LSB first: 1,0,1,0
        apply_reset();
        for (int t = 0; t <= 17; t++) begin
            btn_in = (t < 4) ? {1'b0, pat[t]} : 2'b01;
            tick();
            // steady level starts at t=4, so press lands at 4+6
            exp = {1'b0, t == 10, 2'b00, 2'b00, 1'b0, t == 10, 2'b00,
                   1'b0, t >= 9};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL bounce t=%0d got=%h exp=%h", t, got, exp);
            end
        end
    endtask

    task automatic test_rel_suppress();
        logic [11:0] exp;
        apply_reset();
        for (int t = 0; t <= 20; t++) begin
            btn_in = (t < 10) ? 2'b01 : 2'b00;
            tick();
            // first repeat would be due at t=16, the same edge as the release
            exp = {1'b0, t == 6, 1'b0, t == 16, 2'b00, 1'b0, t == 6, 2'b00,
                   1'b0, (t >= 5 && t <= 14)};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL rel_suppress t=%0d got=%h exp=%h", t, got, exp);
            end
        end
    endtask

    task automatic test_hold_repeat();
        logic [11:0] exp;
        logic        rpt;
        apply_reset();
        for (int t = 0; t <= 50; t++) begin
            btn_in = (t < 40) ? 2'b01 : 2'b00;
            tick();
            rpt = (t >= 16 && t <= 43 && ((t - 16) % 3) == 0);
            exp = {1'b0, t == 6, 1'b0, t == 46, 1'b0, rpt, 1'b0, (t == 6) || rpt,
                   1'b0, (t >= 16 && t <= 45), 1'b0, (t >= 5 && t <= 44)};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL hold_repeat t=%0d got=%h exp=%h", t, got, exp);
            end
        end
    endtask

    task automatic test_no_repeat_ch1();
        logic [11:0] exp;
        apply_reset();
        for (int t = 0; t <= 50; t++) begin
            btn_in = (t < 40) ? 2'b10 : 2'b00;
            tick();
            exp = {t == 6, 1'b0, t == 46, 1'b0, 2'b00, t == 6, 1'b0, 2'b00,
                   (t >= 5 && t <= 44), 1'b0};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL no_repeat_ch1 t=%0d got=%h exp=%h", t, got, exp);
            end
        end
    endtask

    task automatic test_both_channels();
        logic [11:0] exp;
        logic        lv;
        apply_reset();
        for (int t = 0; t <= 22; t++) begin
            btn_in = (t < 12) ? 2'b11 : 2'b00;
            tick();
            lv = (t >= 5 && t <= 16);
            exp = {t == 6, t == 6, t == 18, t == 18, 1'b0, t == 16,
                   t == 6, (t == 6) || (t == 16), 1'b0, (t == 16 || t == 17), lv, lv};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL both_channels t=%0d got=%h exp=%h", t, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid_repeat();
        logic [11:0] exp;
        logic        rpt;
        apply_reset();
        btn_in = 2'b01;
        for (int t = 0; t <= 19; t++) begin
            tick();
            rpt = (t == 16 || t == 19);
            exp = {1'b0, t == 6, 2'b00, 1'b0, rpt, 1'b0, (t == 6) || rpt,
                   1'b0, t >= 16, 1'b0, t >= 5};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL pre_reset t=%0d got=%h exp=%h", t, got, exp);
            end
        end
        // asynchronous: outputs must clear without waiting for an edge
        rst = 1'b0;
        #1;
        vectors++;
        if (got !== 12'h000) begin
            miscompares++;
            $display("FAIL async_reset got=%h exp=%h", got, 12'h000);
        end
        tick();
        tick();
        vectors++;
        if (got !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_held got=%h exp=%h", got, 12'h000);
        end
        rst = 1'b1;
        for (int t = 0; t <= 20; t++) begin
            tick();
            rpt = (t == 16 || t == 19);
            exp = {1'b0, t == 6, 2'b00, 1'b0, rpt, 1'b0, (t == 6) || rpt,
                   1'b0, t >= 16, 1'b0, t >= 5};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL post_reset t=%0d got=%h exp=%h", t, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_rel_suppress();
        test_hold_repeat();
        test_no_repeat_ch1();
        test_both_channels();
        test_reset_mid_repeat();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
